// File: rtl/boot_rom_reader.sv
// Burst reader for a synchronous boot ROM: fetches word_count words starting at base_addr,
// presents each on a valid/ready port and accumulates a 32-bit running checksum.
module boot_rom_reader (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        start,
    input  logic [9:0]  base_addr,
    input  logic [10:0] word_count,
    output logic        rom_csn_o,
    output logic [9:0]  rom_addr_o,
    input  logic [31:0] rom_rdata_i,
    output logic [31:0] data_o,
    output logic [9:0]  addr_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        busy,
    output logic        done,
    output logic [31:0] checksum_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic [9:0]  cur_addr_reg, cur_addr_next;
    logic [10:0] remaining_reg, remaining_next;
    logic [31:0] data_reg, data_next;
    logic [9:0]  addr_reg, addr_next;
    logic [31:0] checksum_reg, checksum_next;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_reg     <= ST_IDLE;
            cur_addr_reg  <= '0;
            remaining_reg <= '0;
            data_reg      <= '0;
            addr_reg      <= '0;
            checksum_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cur_addr_reg  <= cur_addr_next;
            remaining_reg <= remaining_next;
            data_reg      <= data_next;
            addr_reg      <= addr_next;
            checksum_reg  <= checksum_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cur_addr_next  = cur_addr_reg;
        remaining_next = remaining_reg;
        data_next      = data_reg;
        addr_next      = addr_reg;
        checksum_next  = checksum_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    checksum_next = '0;
                    if (word_count != 11'd0) begin
                        cur_addr_next  = base_addr;
                        remaining_next = word_count;
                        state_next     = ST_RD;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_RD: begin
                state_next = ST_CAP;
            end
            ST_CAP: begin
                // ROM data is valid the cycle after the chip-select cycle
                data_next     = rom_rdata_i;
                addr_next     = cur_addr_reg;
                checksum_next = checksum_reg + rom_rdata_i;
                state_next    = ST_HOLD;
            end
            ST_HOLD: begin
                if (ready_i) begin
                    remaining_next = remaining_reg - 11'd1;
                    if (remaining_reg == 11'd1) begin
                        state_next = ST_DONE;
                    end else begin
                        // 10-bit add wraps 0x3FF to 0x000 naturally
                        cur_addr_next = cur_addr_reg + 10'd1;
                        state_next    = ST_RD;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign rom_csn_o  = (state_reg != ST_RD);
    assign rom_addr_o = cur_addr_reg;
    assign data_o     = data_reg;
    assign addr_o     = addr_reg;
    assign valid_o    = (state_reg == ST_HOLD);
    assign busy       = (state_reg != ST_IDLE);
    assign done       = (state_reg == ST_DONE);
    assign checksum_o = checksum_reg;

endmodule

// File: tb/tb_boot_rom_reader.sv
// Scoreboard bench for boot_rom_reader: a ROM model plus a list-based reference of the
// expected word stream and checksum per burst, checked by an independent monitor.
module tb_boot_rom_reader;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] word_count = '0;
    logic        rom_csn_o;
    logic [9:0]  rom_addr_o;
    logic [31:0] rom_rdata_i = '0;
    logic [31:0] data_o;
    logic [9:0]  addr_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] checksum_o;

    boot_rom_reader dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .rom_csn_o  (rom_csn_o),
        .rom_addr_o (rom_addr_o),
        .rom_rdata_i(rom_rdata_i),
        .data_o     (data_o),
        .addr_o     (addr_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .busy       (busy),
        .done       (done),
        .checksum_o (checksum_o)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ROM: one-cycle read latency, output holds while deselected
    always @(posedge CLK) begin
        if (!rom_csn_o) rom_rdata_i <= 32'hA5A50000 | {22'd0, rom_addr_o};
    end

    // ready_i: 0 = low, 1 = high, 2 = random
    int ready_mode = 0;
    initial begin
        forever begin
            @(negedge CLK);
            #1;
            if (ready_mode == 2) ready_i = ($urandom_range(0, 3) != 0);
            else                 ready_i = (ready_mode == 1);
        end
    end

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } word_t;

    word_t       word_q[$];
    logic [31:0] sum_q[$];
    int          csn_cyc_q[$];
    int          done_cnt = 0;
    int          last_done_cyc = 0;
    int          csn_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: addresses wrap modulo 1024, checksum is the plain 32-bit sum of the words
    task automatic model_burst(input logic [9:0] b, input int n);
        logic [31:0] s;
        word_t       w;
        s = 32'd0;
        for (int i = 0; i < n; i++) begin
            w.addr = 10'((int'(b) + i) % 1024);
            w.data = 32'hA5A50000 + 32'(w.addr);
            word_q.push_back(w);
            s = s + w.data;
        end
        sum_q.push_back(s);
    endtask

    // Monitor: samples mid-low-phase, after the bench drivers have settled
    logic        hold_prev = 1'b0;
    logic [31:0] prev_data = '0;
    logic [9:0]  prev_addr = '0;
    initial begin
        word_t w;
        forever begin
            @(negedge CLK);
            #2;
            if (!RSTN) begin
                hold_prev = 1'b0;
            end else begin
                if (!rom_csn_o) begin
                    csn_cnt++;
                    csn_cyc_q.push_back(cyc);
                end
                if (hold_prev && valid_o) begin
                    chk("hold_data_stable", data_o, prev_data);
                    chk("hold_addr_stable", 32'(addr_o), 32'(prev_addr));
                end
                if (valid_o && !ready_i) chk("csn_high_in_hold", 32'(rom_csn_o), 32'd1);
                if (valid_o && ready_i) begin
                    if (word_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got addr %0h data %0h expected none", addr_o, data_o);
                    end else begin
                        w = word_q.pop_front();
                        chk("word_addr", 32'(addr_o), 32'(w.addr));
                        chk("word_data", data_o, w.data);
                    end
                end
                if (done) begin
                    done_cnt++;
                    last_done_cyc = cyc;
                    if (sum_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                    end else begin
                        chk("checksum_at_done", checksum_o, sum_q.pop_front());
                    end
                end
                hold_prev = valid_o && !ready_i;
                prev_data = data_o;
                prev_addr = addr_o;
            end
        end
    end

    task automatic issue_start(input logic [9:0] b, input int n, output int t);
        @(negedge CLK);
        base_addr  = b;
        word_count = 11'(n);
        start      = 1'b1;
        t          = cyc;
        model_burst(b, n);
        @(negedge CLK);
        start      = 1'b0;
        base_addr  = 10'($urandom);
        word_count = 11'($urandom);
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) begin
            @(negedge CLK);
            #3;
        end
        chk("done_seen", 32'(done_cnt), 32'(target));
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !valid_o; i++) begin
            @(negedge CLK);
            #3;
        end
        chk("valid_seen", 32'(valid_o), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_csn"},      32'(rom_csn_o),  32'd1);
        chk({tag, "_rom_addr"}, 32'(rom_addr_o), 32'd0);
        chk({tag, "_data"},     data_o,          32'd0);
        chk({tag, "_addr"},     32'(addr_o),     32'd0);
        chk({tag, "_valid"},    32'(valid_o),    32'd0);
        chk({tag, "_busy"},     32'(busy),       32'd0);
        chk({tag, "_done"},     32'(done),       32'd0);
        chk({tag, "_checksum"}, checksum_o,      32'd0);
    endtask

    initial begin
        int t;
        int c0;
        int exp_done;
        int n;
        exp_done = 0;

        repeat (3) @(negedge CLK);
        #1;
        check_reset_outputs("reset");
        RSTN = 1'b1;

        // Basic burst
        ready_mode = 1;
        @(negedge CLK);
        csn_cyc_q.delete();
        issue_start(10'h010, 2, t);
        exp_done++;
        wait_done(exp_done, 50);
        chk("basic_done_cycle", 32'(last_done_cyc), 32'(t + 7));
        chk("basic_csn_count", 32'(csn_cyc_q.size()), 32'd2);
        if (csn_cyc_q.size() == 2) begin
            chk("basic_csn_first", 32'(csn_cyc_q[0]), 32'(t + 1));
            chk("basic_csn_second", 32'(csn_cyc_q[1]), 32'(t + 4));
        end
        chk("basic_checksum", checksum_o, 32'h4B4A0021);

        // Wrap through 0x3FF -> 0x000, then checksum must hold while idle
        issue_start(10'h3FF, 2, t);
        exp_done++;
        wait_done(exp_done, 50);
        chk("wrap_checksum", checksum_o, 32'h4B4A03FF);
        repeat (3) @(negedge CLK);
        #3;
        chk("checksum_hold", checksum_o, 32'h4B4A03FF);
        chk("idle_after_done", 32'(busy), 32'd0);

        // Backpressure
        ready_mode = 0;
        issue_start(10'h123, 3, t);
        wait_valid(20);
        c0 = csn_cnt;
        repeat (5) @(negedge CLK);
        #3;
        chk("bp_valid_held", 32'(valid_o), 32'd1);
        chk("bp_no_csn", 32'(csn_cnt), 32'(c0));
        ready_mode = 1;
        exp_done++;
        wait_done(exp_done, 60);

        // Zero count
        c0 = csn_cnt;
        issue_start(10'h055, 0, t);
        exp_done++;
        wait_done(exp_done, 20);
        chk("zero_done_cycle", 32'(last_done_cyc), 32'(t + 1));
        chk("zero_no_csn", 32'(csn_cnt), 32'(c0));
        chk("zero_checksum", checksum_o, 32'd0);

        // Start while busy is ignored
        issue_start(10'h200, 4, t);
        @(negedge CLK);
        base_addr  = 10'h0AA;
        word_count = 11'd7;
        start      = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        base_addr  = 10'h1BB;
        word_count = 11'd0;
        start      = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        exp_done++;
        wait_done(exp_done, 80);
        chk("busy_start_done_cycle", 32'(last_done_cyc), 32'(t + 13));
        repeat (6) @(negedge CLK);
        #3;
        chk("busy_start_no_extra_done", 32'(done_cnt), 32'(exp_done));
        chk("busy_start_idle", 32'(busy), 32'd0);

        // Reset in HOLD
        ready_mode = 0;
        issue_start(10'h300, 3, t);
        wait_valid(20);
        @(negedge CLK);
        RSTN = 1'b0;
        #1;
        check_reset_outputs("midreset");
        word_q.delete();
        sum_q.delete();
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
        ready_mode = 1;
        c0 = csn_cnt;
        repeat (4) @(negedge CLK);
        #3;
        chk("no_resume_busy", 32'(busy), 32'd0);
        chk("no_resume_csn", 32'(csn_cnt), 32'(c0));
        issue_start(10'h3FE, 1, t);
        exp_done++;
        wait_done(exp_done, 30);
        chk("post_reset_done_cycle", 32'(last_done_cyc), 32'(t + 4));
        chk("post_reset_checksum", checksum_o, 32'hA5A503FE);

        // Full 1024-word sweep
        issue_start(10'h2A5, 1024, t);
        exp_done++;
        wait_done(exp_done, 3300);
        chk("full_done_cycle", 32'(last_done_cyc), 32'(t + 3 * 1024 + 1));

        // Randomized bursts under random backpressure
        ready_mode = 2;
        for (int k = 0; k < 25; k++) begin
            n = $urandom_range(0, 10);
            issue_start(10'($urandom_range(0, 1023)), n, t);
            exp_done++;
            wait_done(exp_done, 40 * n + 40);
        end
        ready_mode = 1;
        repeat (3) @(negedge CLK);
        #3;
        chk("words_drained", 32'(word_q.size()), 32'd0);
        chk("sums_drained", 32'(sum_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
